// File: rtl/pcm_word_program.sv
// PCM word program sequencer: clear-status, setup, program, poll, read-array.
// Optional PCM_PROG_TIMEOUT_EN bounds the status poll at 4096 reads.
module pcm_word_program (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [22:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  status,
  output logic [22:0] addr,
  inout  wire  [15:0] data,
  output logic        pcm_rst_n,
  output logic        ce_n,
  output logic        oe_n,
  output logic        we_n
);

  typedef enum logic [2:0] {
    RWAIT, IDLE, CLR, SETUP, PROG, POLL, ARRAY, FIN
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic [15:0] wdat;
  logic [15:0] wval;
  logic        wc;
  logic        rc;
  logic        poll_end;
  logic        poll_to;

`ifdef PCM_PROG_TIMEOUT_EN
  logic [11:0] pcnt;
  assign poll_to = poll_end && !status[7] && (pcnt == 12'hFFF);
`else
  assign poll_to = 1'b0;
`endif

  assign poll_end = (state == POLL) && (cnt == 4'd13);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 4'd1;
    unique case (state)
      RWAIT: if (cnt == 4'd15) begin
        state_nx = IDLE;
        cnt_nx   = 4'd0;
      end
      IDLE: begin
        cnt_nx = 4'd0;
        if (start) state_nx = CLR;
      end
      CLR, SETUP, PROG, ARRAY: if (cnt == 4'd7) begin
        cnt_nx = 4'd0;
        unique case (state)
          CLR:     state_nx = SETUP;
          SETUP:   state_nx = PROG;
          PROG:    state_nx = POLL;
          default: state_nx = FIN;
        endcase
      end
      POLL: if (poll_end) begin
        cnt_nx = 4'd0;
        if (status[7] || poll_to) state_nx = ARRAY;
      end
      FIN: begin
        cnt_nx   = 4'd0;
        state_nx = IDLE;
      end
      default: begin
        cnt_nx   = 4'd0;
        state_nx = RWAIT;
      end
    endcase
  end

  // Bus strobes decode straight from state and cycle count
  always_comb begin
    wc   = (state == CLR) || (state == SETUP) ||
           (state == PROG) || (state == ARRAY);
    rc   = (state == POLL);
    we_n = !(wc && cnt < 4'd6);
    oe_n = !(rc && cnt < 4'd12);
    ce_n = we_n && oe_n;
    busy = (state != IDLE);
    done = (state == FIN);
    wval = 16'h00FF;
    unique case (state)
      CLR:     wval = 16'h0050;
      SETUP:   wval = 16'h0040;
      PROG:    wval = wdat;
      default: wval = 16'h00FF;
    endcase
  end

  assign data = wc ? wval : 16'hzzzz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RWAIT;
      cnt       <= 4'd0;
      pcm_rst_n <= 1'b0;
      addr      <= 23'd0;
      wdat      <= 16'd0;
      status    <= 8'h00;
      err       <= 1'b0;
`ifdef PCM_PROG_TIMEOUT_EN
      pcnt      <= 12'd0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pcm_rst_n <= 1'b1;
      if (state == IDLE && start) begin
        addr <= wr_addr;
        wdat <= wr_data;
        err  <= 1'b0;
`ifdef PCM_PROG_TIMEOUT_EN
        pcnt <= 12'd0;
`endif
      end
      if (rc && cnt == 4'd11) status <= data[7:0];
      if (poll_end && status[7])
        err <= status[4] | status[3] | status[1];
`ifdef PCM_PROG_TIMEOUT_EN
      if (poll_end && !status[7]) begin
        if (poll_to) err <= 1'b1;
        else pcnt <= pcnt + 12'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_pcm_word_program.sv
// Bench for pcm_word_program: vector table, bus scoreboard, reset/busy corners.
module tb_pcm_word_program;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [22:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy, done, err;
  logic [7:0]  status;
  logic [22:0] addr;
  wire  [15:0] data;
  logic        pcm_rst_n, ce_n, oe_n, we_n;

  pcm_word_program dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .status(status),
    .addr(addr), .data(data), .pcm_rst_n(pcm_rst_n),
    .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n)
  );

  always #5 clk = ~clk;

  logic [7:0] poll_val = 8'h00;
  assign data = !oe_n ? {8'h00, poll_val} : 16'hzzzz;

  typedef struct {
    logic        wr;
    logic [22:0] a;
    logic [15:0] d;
  } bus_t;
  bus_t q[$];

  typedef struct {
    logic [22:0] a;
    logic [15:0] d;
    int          nz;
    logic [7:0]  fv;
    logic        e_err;
    logic [7:0]  e_st;
    int          e_lat;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nzero = 0;
  logic [7:0] fin_val = 8'h80;
  int nrd = 0;
  int nwr = 0;
  int ndone = 0;
  logic prev_we = 1'b1;
  logic prev_oe = 1'b1;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bus_chk(input logic wr, input logic [22:0] a,
                         input logic [15:0] d);
    bus_t e;
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL bus_unexpected: got wr=%0d a=%0h want none", wr, a);
    end else begin
      e = q.pop_front();
      chk("bus_kind", {31'd0, wr}, {31'd0, e.wr});
      chk("bus_addr", {9'd0, a}, {9'd0, e.a});
      if (e.wr) chk("bus_data", {16'd0, d}, {16'd0, e.d});
    end
  endtask

  // Device model and bus monitor
  always @(negedge clk) begin
    if (!we_n && prev_we) begin
      nwr++;
      bus_chk(1'b1, addr, data);
    end
    if (!oe_n && prev_oe) begin
      poll_val = (nrd < nzero) ? 8'h00 : fin_val;
      nrd++;
      bus_chk(1'b0, addr, 16'h0000);
    end
    prev_we = we_n;
    prev_oe = oe_n;
    if (done) ndone++;
  end

  task automatic push_seq(input logic [22:0] a, input logic [15:0] d,
                          input int nreads);
    q.push_back('{1'b1, a, 16'h0050});
    q.push_back('{1'b1, a, 16'h0040});
    q.push_back('{1'b1, a, d});
    for (int i = 0; i < nreads; i++) q.push_back('{1'b0, a, 16'h0000});
    q.push_back('{1'b1, a, 16'h00FF});
  endtask

  task automatic run_op(input logic [22:0] a, input logic [15:0] d,
                        input int nz, input logic [7:0] fv,
                        input int nreads, input int limit,
                        output int lat);
    int t0;
    int n;
    push_seq(a, d, nreads);
    nzero = nz;
    fin_val = fv;
    nrd = 0;
    wr_addr = a;
    wr_data = d;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done");
    end
    lat = cyc - t0;
  endtask

  task automatic count_rwait(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  vec_t vecs[6];
  int lat;
  int n;
  int d0;

  initial begin
    vecs[0] = '{23'h000012, 16'hA5C3, 0, 8'h80, 1'b0, 8'h80, 47};
    vecs[1] = '{23'h000034, 16'h1234, 2, 8'h80, 1'b0, 8'h80, 75};
    vecs[2] = '{23'h000056, 16'hBEEF, 0, 8'h90, 1'b1, 8'h90, 47};
    vecs[3] = '{23'h7FFFFF, 16'hFFFF, 1, 8'h82, 1'b1, 8'h82, 61};
    vecs[4] = '{23'h000000, 16'h0000, 0, 8'h88, 1'b1, 8'h88, 47};
    vecs[5] = '{23'h2AAAAA, 16'h5555, 0, 8'hA0, 1'b0, 8'hA0, 47};

    rst_n = 1'b0;
    start = 1'b0;
    wr_addr = 23'd0;
    wr_data = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_pcm_rst_n", {31'd0, pcm_rst_n}, 32'd0);
    chk("rst_strobes", {29'd0, ce_n, oe_n, we_n}, 32'd7);
    chk("rst_addr", {9'd0, addr}, 32'd0);
    chk("rst_status", {24'd0, status}, 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd4);
    rst_n = 1'b1;
    count_rwait(n);
    chk("rwait_cycles", n, 16);
    chk("pcm_rst_n_up", {31'd0, pcm_rst_n}, 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].d, vecs[i].nz, vecs[i].fv,
             vecs[i].nz + 1, 300, lat);
      chk("latency", lat, vecs[i].e_lat);
      chk("err", {31'd0, err}, {31'd0, vecs[i].e_err});
      chk("status", {24'd0, status}, {24'd0, vecs[i].e_st});
      chk("bus_drained", q.size(), 0);
      @(negedge clk);
      chk("addr_hold", {9'd0, addr}, {9'd0, vecs[i].a});
      chk("idle", {31'd0, busy}, 32'd0);
    end

    // Start pulses while busy and during FIN are ignored
    d0 = ndone;
    push_seq(23'h000321, 16'hCAFE, 1);
    nzero = 0;
    fin_val = 8'h80;
    nrd = 0;
    wr_addr = 23'h000321;
    wr_data = 16'hCAFE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    wr_addr = 23'h111111;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    repeat (60) begin
      if (busy) n++;
      @(negedge clk);
    end
    chk("no_restart", n, 0);
    chk("one_done", ndone - d0, 1);
    chk("busy_addr_kept", {9'd0, addr}, 32'h000321);
    chk("busy_drained", q.size(), 0);

    // Reset during the PROG write aborts the bus cycle at once
    push_seq(23'h000444, 16'h0F0F, 1);
    nzero = 0;
    nwr = 0;
    wr_addr = 23'h000444;
    wr_data = 16'h0F0F;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (nwr < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("prog_reached", nwr, 3);
    chk("prog_we", {31'd0, we_n}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {29'd0, ce_n, oe_n, we_n}, 32'd7);
    chk("abort_pcm_rst_n", {31'd0, pcm_rst_n}, 32'd0);
    chk("abort_addr", {9'd0, addr}, 32'd0);
    chk("abort_flags", {29'd0, busy, done, err}, 32'd4);
    q.delete();
    rst_n = 1'b1;
    count_rwait(n);
    chk("abort_rwait", n, 16);

`ifdef PCM_PROG_TIMEOUT_EN
    run_op(23'h000077, 16'h1357, 32'h7FFFFFFF, 8'h80, 4096, 60000, lat);
    chk("to_latency", lat, 47 + 14 * 4095);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_drained", q.size(), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcm_word_program.md
PCM_WORD_PROGRAM -- requirements
Module: pcm_word_program

Interface
REQ-001 Port clk, input, 1: single rising-edge clock for all logic.
REQ-002 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-003 Port start, input, 1: request one word program; sampled only in IDLE.
REQ-004 Port wr_addr, input, 23: target word address; captured on accepted start.
REQ-005 Port wr_data, input, 16: word to program; captured on accepted start.
REQ-006 Port busy, output, 1: high in every state except IDLE.
REQ-007 Port done, output, 1: one-cycle pulse at operation end.
REQ-008 Port err, output, 1: error flag of the last operation; held until the next accepted start.
REQ-009 Port status, output, 8: last status byte read from the device.
REQ-010 Port addr, output, 23: PCM address bus.
REQ-011 Port data, inout, 16: PCM data bus; driven only during write cycles, high-Z otherwise.
REQ-012 Ports pcm_rst_n, ce_n, oe_n, we_n, output, 1 each: PCM reset, chip enable, output enable and write enable, all active-low.

Function
REQ-013 Write cycle (WC) SHALL last 8 clocks:
  - cycles 1-6: ce_n=0, we_n=0, oe_n=1, addr and data driven;
  - cycles 7-8: ce_n=1, we_n=1, data still driven.
REQ-014 Read cycle (RC) SHALL last 14 clocks:
  - data is high-Z throughout;
  - cycles 1-12: ce_n=0, oe_n=0;
  - status <= data[7:0] on the edge ending cycle 12;
  - cycles 13-14: ce_n=1, oe_n=1.
REQ-015 After reset, the block SHALL drive pcm_rst_n=1 and stay in state RWAIT for 16 cycles (busy=1), then enter IDLE.
REQ-016 States SHALL be RWAIT, IDLE, CLR, SETUP, PROG, POLL, ARRAY, FIN.
REQ-017 IDLE with start=1 SHALL capture wr_addr and wr_data, clear err and go to CLR; start is ignored in all other states.
REQ-018 Command sequence, all cycles at the captured address:
  - CLR: WC with 0x0050;
  - SETUP: WC with 0x0040;
  - PROG: WC with the captured data;
  - POLL: repeated RCs;
  - ARRAY: WC with 0x00FF;
  - FIN: done=1 for one cycle, then IDLE.
REQ-019 POLL SHALL exit to ARRAY after the first RC whose data[7]=1; otherwise it starts another RC immediately.
REQ-020 On POLL exit, err SHALL be set to status[4] | status[3] | status[1].
REQ-021 With one poll, done SHALL be high exactly 47 cycles after the cycle in which start was sampled (24 + 14 + 8 + 1).
REQ-022 addr SHALL hold the captured address from CLR through ARRAY and retain its value in IDLE.
REQ-023 done and start in the same cycle: done completes; start is ignored in FIN and takes effect only in IDLE.

Reset
REQ-024 While rst_n=0, on each clock the block SHALL set:
  - state=RWAIT, counters cleared;
  - pcm_rst_n=0, ce_n=oe_n=we_n=1, data high-Z;
  - addr=0, status=0x00, err=0, done=0, busy=1.
REQ-025 Reset asserted mid-operation SHALL abort within one clock with the same values; no partial bus cycle continues.

Configuration
REQ-026 Macro PCM_PROG_TIMEOUT_EN:
  - defined: a 12-bit poll counter limits POLL to 4096 RCs; on the 4096th RC with data[7]=0, err=1 and the block goes to ARRAY;
  - undefined: POLL waits indefinitely and there is no counter.

Verification
REQ-027 Device model returns 0x80 on the first poll; start with wr_addr=0x000012, wr_data=0xA5C3 -> bus shows writes 0x50, 0x40, 0xA5C3, one read, write 0xFF, all at 0x000012; done at cycle +47; err=0; status=0x80.
REQ-028 Model returns 0x00 twice, then 0x80 -> three RCs; done at cycle +75.
REQ-029 Model returns 0x90 -> err=1, status=0x90; the 0xFF write still occurs.
REQ-030 Assert rst_n=0 during a PROG WC -> next cycle: ce_n=we_n=1, data high-Z, pcm_rst_n=0; after release, 16 busy cycles before IDLE.
REQ-031 Pulse start while busy -> no second sequence starts; exactly one done.
REQ-032 With PCM_PROG_TIMEOUT_EN defined and the model always returning 0x00 -> 4096 RCs, err=1, the 0xFF write occurs, then done.
